// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Purpose  : Sequential binary-to-packed-BCD converter (shift-and-add-3).
//             Sits between the frequency meter's binary count and the
//             seven-segment display driver so the display reads decimal.
//             One conversion takes BIN_W shift cycles plus one finish cycle.
//             The result word is only ever replaced as a whole.
//
//  Ports    : Clk       in   system clock
//             Rst       in   asynchronous, active-high reset
//             Bin       in   [BIN_W-1:0] value to convert (sampled on accept)
//             Start     in   conversion request (pulse or level)
//             Busy      out  conversion in progress
//             Done      out  one-cycle pulse when Bcd/Overflow are refreshed
//             Bcd       out  [4*DIGITS-1:0] packed BCD, digit 0 at [3:0]
//             Overflow  out  last value exceeded 10^DIGITS-1 (Bcd saturated)
//
//  Revision : 1.0  initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [BIN_W-1:0]      Bin,
    input  logic                  Start,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   Bcd,
    output logic                  Overflow
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CAT_W = c_BCD_W + BIN_W;
    localparam int c_CNT_W = $clog2(BIN_W + 1);
    // Comparison is done at least 64 bits wide so 10^DIGITS-1 always fits
    // (valid for DIGITS up to 19).
    localparam int c_CMP_W = (BIN_W > 64) ? BIN_W : 64;

    function automatic logic [63:0] f_pow10_m1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [c_CMP_W-1:0] c_LIMIT  = c_CMP_W'(f_pow10_m1(DIGITS));
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(BIN_W);
    localparam logic [c_CNT_W-1:0] c_PENULT = c_CNT_W'(BIN_W - 1);
    localparam logic [c_BCD_W-1:0] c_SAT    = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [BIN_W-1:0]     r_shift;
    logic [c_BCD_W-1:0]   r_scratch;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_ovf;
    logic                 r_busy;
    logic                 r_done;
    logic [c_BCD_W-1:0]   r_bcd;
    logic                 r_overflow;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [c_CMP_W-1:0]   w_bin_ext;
    logic                 w_bin_over;
    logic [c_BCD_W-1:0]   w_adj;
    logic [c_CAT_W-1:0]   w_cat_next;

    assign w_bin_ext  = c_CMP_W'(Bin);
    assign w_bin_over = (w_bin_ext > c_LIMIT);

    // Add-3 correction on every digit that would reach 10+ after doubling.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5)
                               ? (r_scratch[4*i +: 4] + 4'd3)
                               : r_scratch[4*i +: 4];
    end

    // Corrected scratch and the binary shift register move left as one word;
    // the bit falling out of the top of the scratch is discarded (only
    // reachable for values that are saturated anyway).
    assign w_cat_next = {w_adj, r_shift} << 1;

    // ------------------------------------------------------------------
    // Control FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_shift   <= Bin;
                        r_scratch <= '0;
                        r_count   <= '0;
                        r_ovf     <= w_bin_over;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    if (r_count == c_LAST) begin
                        // All bits shifted in: publish the whole result at once.
                        r_bcd      <= r_ovf ? c_SAT : r_scratch;
                        r_overflow <= r_ovf;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        {r_scratch, r_shift} <= w_cat_next;
                        r_count              <= r_count + 1'b1;
                        // Busy spans exactly BIN_W cycles from the accept edge.
                        if (r_count == c_PENULT) begin
                            r_busy <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Bcd      = r_bcd;
    assign Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_seq
//  Purpose  : Directed self-checking bench for bin_to_bcd_seq. Expected
//             BCD words, latencies and busy widths are hand-computed.
//             Inputs are driven and outputs sampled 1 ns after rising edges.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int c_BIN_W   = 32;
    localparam int c_DIGITS  = 8;
    localparam int c_LAT     = 33;   // accept edge -> Done edge
    localparam int c_BUSY    = 32;   // cycles with Busy high per conversion
    localparam int c_PERIOD  = 34;   // edges between Done pulses, Start held

    logic                    Clk;
    logic                    Rst;
    logic [c_BIN_W-1:0]      Bin;
    logic                    Start;
    logic                    Busy;
    logic                    Done;
    logic [4*c_DIGITS-1:0]   Bcd;
    logic                    Overflow;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(
        .BIN_W  (c_BIN_W),
        .DIGITS (c_DIGITS)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Bin      (Bin),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .Bcd      (Bcd),
        .Overflow (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until Done is seen (bounded); returns number of edges taken.
    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!Done && edges < 200);
    endtask

    // One full conversion from IDLE with a single-cycle Start pulse.
    task automatic convert(input logic [31:0] v, input logic [31:0] exp_bcd,
                           input logic exp_ovf, input string tag);
        int n;
        int busy_n;
        Bin   = v;
        Start = 1'b1;
        tick();                         // accept edge
        Start = 1'b0;
        Bin   = $urandom;               // must not affect the running conversion
        n      = 0;
        busy_n = int'(Busy);
        while (!Done && n < 200) begin
            tick();
            n++;
            if (!Done) busy_n += int'(Busy);
        end
        check({tag, ".latency"},  64'(n),        64'(c_LAT));
        check({tag, ".busy_len"}, 64'(busy_n),   64'(c_BUSY));
        check({tag, ".busy_dn"},  64'(Busy),     64'd0);
        check({tag, ".bcd"},      64'(Bcd),      64'(exp_bcd));
        check({tag, ".ovf"},      64'(Overflow), 64'(exp_ovf));
        tick();
        check({tag, ".done_1cy"}, 64'(Done),     64'd0);
    endtask

    initial begin
        int n;
        int done_cnt;

        Rst   = 1'b1;
        Start = 1'b0;
        Bin   = '0;
        #2;
        check("por.bcd",  64'(Bcd),      64'd0);
        check("por.ovf",  64'(Overflow), 64'd0);
        check("por.busy", 64'(Busy),     64'd0);
        check("por.done", 64'(Done),     64'd0);
        tick();
        tick();
        Rst = 1'b0;
        tick();

        // Async reset pulse while idle, with a non-zero result held.
        convert(32'd763, 32'h0000_0763, 1'b0, "pre763");
        #2;
        Rst = 1'b1;
        #1;                             // well before the next rising edge
        check("arst.bcd",  64'(Bcd),      64'd0);
        check("arst.ovf",  64'(Overflow), 64'd0);
        check("arst.busy", 64'(Busy),     64'd0);
        check("arst.done", 64'(Done),     64'd0);
        tick();
        Rst = 1'b0;
        tick();

        // Basic conversions.
        convert(32'd0,        32'h0000_0000, 1'b0, "zero");
        convert(32'd12345678, 32'h1234_5678, 1'b0, "c12345678");
        convert(32'd3051,     32'h0000_3051, 1'b0, "c3051");

        // Result held between conversions while inputs wiggle.
        Bin = 32'hDEAD_BEEF;
        repeat (5) tick();
        check("hold.bcd",  64'(Bcd),  64'h0000_3051);
        check("hold.busy", 64'(Busy), 64'd0);

        convert(32'd763,       32'h0000_0763, 1'b0, "c763");

        // Range boundary and saturation.
        convert(32'd99999999,  32'h9999_9999, 1'b0, "max");
        convert(32'd100000000, 32'h9999_9999, 1'b1, "ovf");
        convert(32'd5,         32'h0000_0005, 1'b0, "after_ovf");

        // Start held high: back-to-back, each result is the Bin at its accept edge.
        Bin   = 32'd1;
        Start = 1'b1;
        tick();                         // accept 1
        Bin = 32'd2;                    // during SHIFT: no effect
        wait_done(n);
        check("b2b1.latency", 64'(n),   64'(c_LAT));
        check("b2b1.bcd",     64'(Bcd), 64'd1);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) Bin = 32'd3;    // 2 accepted on the edge leaving DONE
        end while (!Done && n < 200);
        check("b2b2.period",  64'(n),   64'(c_PERIOD));
        check("b2b2.bcd",     64'(Bcd), 64'd2);
        tick();                         // accept 3
        Start = 1'b0;
        Bin   = 32'd7;
        wait_done(n);
        check("b2b3.period",  64'(n),   64'(c_PERIOD - 1));
        check("b2b3.bcd",     64'(Bcd), 64'd3);
        tick();

        // Reset in the middle of a conversion after a prior result.
        convert(32'd763, 32'h0000_0763, 1'b0, "pre_mid");
        Bin   = 32'd12345678;
        Start = 1'b1;
        tick();                         // accept
        Start = 1'b0;
        repeat (16) tick();             // 16 shifts done
        Rst = 1'b1;
        #1;
        check("mid.bcd",  64'(Bcd),      64'd0);
        check("mid.busy", 64'(Busy),     64'd0);
        check("mid.done", 64'(Done),     64'd0);
        check("mid.ovf",  64'(Overflow), 64'd0);
        tick();
        Rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) done_cnt++;
        end
        check("mid.no_done", 64'(done_cnt), 64'd0);
        check("mid.bcd_kept", 64'(Bcd), 64'd0);
        convert(32'd3051, 32'h0000_3051, 1'b0, "post_mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
